// File: rtl/led_sequencer_if.sv
// Command handshake bundle for the LED sequencer: a valid/ready channel carrying mode and burst count.
interface led_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [3:0] cmd_count;

    modport master (output cmd_valid, output cmd_mode, output cmd_count, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_mode, input cmd_count, output cmd_ready);
endinterface

// File: rtl/led_sequencer.sv
// LED sequencer: OFF / ON / free-running BLINK / counted BURST driven from a valid/ready command port.
module led_sequencer #(
    parameter int unsigned CLK_FREQ_KHz = 50000,
    parameter int unsigned STEP_FREQ_Hz = 2
) (
    input  logic             clk,
    input  logic             rst,
    led_sequencer_if.slave   cmd,
    output logic             led,
    output logic             busy,
    output logic             done
);

    localparam int unsigned STEP_CYCLES = (CLK_FREQ_KHz * 1000) / STEP_FREQ_Hz;
    localparam int unsigned CNT_W       = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned PULSE_W     = 4;
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_BURST = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        SOLID,
        BLINK,
        BURST_ON,
        BURST_OFF
    } state_t;

    state_t               state, state_d;
    logic [CNT_W-1:0]     step, step_d;
    logic [PULSE_W-1:0]   pulse, pulse_d;
    logic                 led_d, busy_d, done_d;
    logic                 ready, ready_d;
    logic                 accept;
    logic                 step_end;

    assign cmd.cmd_ready = ready;
    assign accept        = cmd.cmd_valid && ready;
    assign step_end      = (step == STEP_LAST);

    // State and all outputs registered together; reset wins over any command on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            step  <= '0;
            pulse <= '0;
            led   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            ready <= 1'b1;
        end else begin
            state <= state_d;
            step  <= step_d;
            pulse <= pulse_d;
            led   <= led_d;
            busy  <= busy_d;
            done  <= done_d;
            ready <= ready_d;
        end
    end

    always_comb begin
        state_d = state;
        step_d  = '0;
        pulse_d = pulse;
        led_d   = led;
        busy_d  = busy;
        done_d  = 1'b0;

        if (accept) begin
            pulse_d = '0;
            busy_d  = 1'b0;
            unique case (cmd.cmd_mode)
                MODE_OFF: begin
                    state_d = IDLE;
                    led_d   = 1'b0;
                end
                MODE_ON: begin
                    state_d = SOLID;
                    led_d   = 1'b1;
                end
                MODE_BLINK: begin
                    state_d = BLINK;
                    led_d   = 1'b1;
                end
                MODE_BURST: begin
                    if (cmd.cmd_count != '0) begin
                        state_d = BURST_ON;
                        led_d   = 1'b1;
                        busy_d  = 1'b1;
                        pulse_d = cmd.cmd_count;
                    end else begin
                        state_d = IDLE;
                        led_d   = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end else begin
            unique case (state)
                IDLE, SOLID: ;
                BLINK: begin
                    if (step_end) led_d = ~led;
                    else          step_d = step + CNT_W'(1);
                end
                BURST_ON: begin
                    if (step_end) begin
                        state_d = BURST_OFF;
                        led_d   = 1'b0;
                    end else begin
                        step_d = step + CNT_W'(1);
                    end
                end
                BURST_OFF: begin
                    if (step_end) begin
                        pulse_d = pulse - PULSE_W'(1);
                        if (pulse_d != '0) begin
                            state_d = BURST_ON;
                            led_d   = 1'b1;
                        end else begin
                            state_d = IDLE;
                            led_d   = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        step_d = step + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Commands are held off during a burst and on the cycle its done pulse is visible.
        ready_d = ((state_d == IDLE) || (state_d == SOLID) || (state_d == BLINK)) && !done_d;
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed self-checking bench for led_sequencer with STEP_CYCLES = 4.
module tb_led_sequencer;

    logic clk;
    logic rst;
    logic led, busy, done;
    int   passed;
    int   total;

    led_sequencer_if cmd_if();

    led_sequencer #(
        .CLK_FREQ_KHz (1),
        .STEP_FREQ_Hz (250)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .cmd  (cmd_if),
        .led  (led),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic check_all(input string tag, input logic e_led, input logic e_busy,
                             input logic e_done, input logic e_ready);
        check({tag, ".led"},   led,              e_led);
        check({tag, ".busy"},  busy,             e_busy);
        check({tag, ".done"},  done,             e_done);
        check({tag, ".ready"}, cmd_if.cmd_ready, e_ready);
    endtask

    // Offer one command for exactly one edge; returns one cycle after the accepting edge.
    task automatic send(input logic [1:0] mode, input logic [3:0] count);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_mode  = mode;
        cmd_if.cmd_count = count;
        tick();
        cmd_if.cmd_valid = 1'b0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst              = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_mode  = 2'd0;
        cmd_if.cmd_count = 4'd0;

        // Reset, including a BLINK command offered on a reset edge
        tick();
        tick();
        send(2'd2, 4'd0);
        check_all("reset_hold", 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        tick();
        check_all("idle", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_all("idle2", 1'b0, 1'b0, 1'b0, 1'b1);

        // BLINK: 4 on, 4 off, repeating
        send(2'd2, 4'd0);
        for (int i = 0; i < 18; i++) begin
            check("blink.led", led, (((i / 4) % 2) == 0));
            check("blink.ready", cmd_if.cmd_ready, 1'b1);
            check("blink.busy", busy, 1'b0);
            tick();
        end

        // OFF mid-phase stops the blink on the next cycle
        send(2'd0, 4'd0);
        for (int i = 0; i < 9; i++) begin
            check_all("off_after_blink", 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end

        // BURST k=3 with a competing ON command offered mid-burst
        send(2'd3, 4'd3);
        for (int c = 1; c <= 24; c++) begin
            check_all("burst3", (((c - 1) / 4) % 2) == 0, 1'b1, 1'b0, 1'b0);
            if (c >= 5 && c <= 12) begin
                cmd_if.cmd_valid = 1'b1;
                cmd_if.cmd_mode  = 2'd1;
            end else begin
                cmd_if.cmd_valid = 1'b0;
            end
            tick();
        end
        check_all("burst3_done", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check_all("burst3_after", 1'b0, 1'b0, 1'b0, 1'b1);

        // BURST k=0: immediate done pulse, no busy
        send(2'd3, 4'd0);
        check_all("burst0_done", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check_all("burst0_after", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_all("burst0_idle", 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset during the second BURST_ON of a k=2 burst
        send(2'd3, 4'd2);
        for (int c = 1; c < 10; c++) tick();
        check_all("burst2_second_on", 1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        check_all("burst2_in_reset", 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_all("burst2_after_reset", 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // ON holds steadily, then a BURST k=1 aborts SOLID
        send(2'd1, 4'd0);
        for (int i = 0; i < 6; i++) begin
            check_all("solid", 1'b1, 1'b0, 1'b0, 1'b1);
            tick();
        end
        send(2'd3, 4'd1);
        for (int c = 1; c <= 8; c++) begin
            check_all("burst1", (c <= 4), 1'b1, 1'b0, 1'b0);
            tick();
        end
        check_all("burst1_done", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check_all("burst1_after", 1'b0, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 SHALL have parameter CLK_FREQ_KHz, default 50000: clock frequency in kHz.
REQ-002 SHALL have parameter STEP_FREQ_Hz, default 2: step rate in Hz; one step is one LED on/off phase.
REQ-003 SHALL derive STEP_CYCLES = (CLK_FREQ_KHz*1000)/STEP_FREQ_Hz; step counter width = clog2(STEP_CYCLES).
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port cmd_valid, input, 1 bit: command offered.
REQ-007 SHALL have port cmd_ready, output, 1 bit: command can be accepted this cycle.
REQ-008 SHALL have port cmd_mode, input, 2 bits: 0=OFF, 1=ON, 2=BLINK, 3=BURST.
REQ-009 SHALL have port cmd_count, input, 4 bits: number of pulses for BURST; ignored for other modes.
REQ-010 SHALL have port led, output, 1 bit: registered LED drive.
REQ-011 SHALL have port busy, output, 1 bit: high while a burst is in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when a burst completes.

Function
REQ-013 SHALL implement the states IDLE (led 0), SOLID (led 1), BLINK, BURST_ON and BURST_OFF.
REQ-014 SHALL accept a command on a rising edge where cmd_valid=1 and cmd_ready=1; cmd_valid without cmd_ready is held off and SHALL have no effect.
REQ-015 SHALL drive cmd_ready=1 in IDLE, SOLID and BLINK, and 0 in BURST_ON and BURST_OFF; a command aborts BLINK or SOLID immediately.
REQ-016 SHALL register the new state and led value on the accepting edge, so the new led is visible one cycle after the accepting cycle; the step counter SHALL clear to 0 on that edge.
REQ-017 OFF -> IDLE, led=0; ON -> SOLID, led=1.
REQ-018 BLINK -> led=1 on acceptance, then toggle each time the step counter reaches STEP_CYCLES-1; the counter then wraps to 0; runs indefinitely.
REQ-019 BURST with cmd_count=k>0 -> BURST_ON, led=1, pulse counter loaded with k, busy=1.
REQ-020 BURST_ON -> BURST_OFF after STEP_CYCLES cycles, with led=0.
REQ-021 BURST_OFF -> after STEP_CYCLES cycles, decrement the pulse counter.
REQ-022 BURST_OFF -> if the pulse counter is still nonzero, return to BURST_ON with led=1.
REQ-023 BURST_OFF -> if the pulse counter reaches 0, go to IDLE with led=0, busy=0 and done=1 for exactly that one cycle.
REQ-024 BURST with cmd_count=0 SHALL go directly to IDLE with led=0, busy stays 0, and done pulses for one cycle after acceptance.
REQ-025 SHALL hold cmd_ready low on the cycle done is high; cmd_ready SHALL return high the next cycle.
REQ-026 SHALL keep the step counter at 0 in IDLE and SOLID.
REQ-027 SHALL perform step-counter comparisons at full counter width; the counter SHALL never exceed STEP_CYCLES-1.
REQ-028 SHALL keep done and busy registered, never combinational from inputs.

Reset
REQ-029 While rst=1 SHALL force state=IDLE, led=0, busy=0, done=0, step counter=0 and pulse counter=0; cmd_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-030 Reset SHALL take priority over any command on the same edge and SHALL abort a burst mid-pulse with no done pulse.

Verification (CLK_FREQ_KHz=1, STEP_FREQ_Hz=250 -> STEP_CYCLES=4)
REQ-031 Reset, then idle -> led=0, busy=0, done=0, cmd_ready=1.
REQ-032 Cmd BLINK -> led=1 for 4 cycles, 0 for 4 cycles, repeating.
REQ-033 Cmd OFF during BLINK -> led=0 next cycle; the blink stops.
REQ-034 Cmd BURST k=3 -> led pattern 1111 0000 x3 (24 cycles).
REQ-035 BURST k=3 pass condition -> busy=1 throughout the burst; done=1 on cycle 25 only; cmd_ready=0 for cycles 1-25.
REQ-036 Cmd_valid asserted during the burst -> ignored; the pattern is unchanged.
REQ-037 Cmd BURST k=0 -> done pulse next cycle; led stays 0; busy never high.
REQ-038 rst asserted during the second BURST_ON -> led=0, busy=0, no done, cmd_ready=1 after release.
